// File: rtl/wid_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | wid_pkg : shared types and helpers for the wid width-packing datapath  |
// | Rev 1.0 : initial release                                              |
// +-----------------------------------------------------------------------+
package wid_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

  // Upper bound on lane count that keep_mask can describe.
  localparam int unsigned KEEP_MAX = 64;

  // Lanes 0..cnt set, lanes at or beyond ratio forced clear.
  function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned cnt,
                                                    input int unsigned ratio);
    logic [KEEP_MAX-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < KEEP_MAX; i++) begin
      if ((i <= cnt) && (i < ratio)) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wid_beat_packer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | wid_beat_packer : packs RATIO narrow beats into one wide word with a   |
// |                   lane-keep mask and s_last-driven partial flush       |
// | Rev 1.0 : initial release                                              |
// +-----------------------------------------------------------------------+
module wid_beat_packer
  import wid_pkg::*;
#(
  parameter  int IN_WIDTH  = 8,
  parameter  int RATIO     = 4,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO,
  localparam int CNT_W     = $clog2(RATIO)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IN_WIDTH-1:0]  s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic [RATIO-1:0]     m_keep,
  output logic                 m_last
);

  pack_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [RATIO-1:0]     hold_keep_q, hold_keep_d;
  logic                 hold_last_q, hold_last_d;
  logic                 m_valid_q, m_valid_d;
  logic [OUT_WIDTH-1:0] m_data_q, m_data_d;
  logic [RATIO-1:0]     m_keep_q, m_keep_d;
  logic                 m_last_q, m_last_d;

  logic                 in_xfer;
  logic                 slot_free;
  logic                 completing;
  logic [KEEP_MAX-1:0]  keep_full;
  logic [RATIO-1:0]     lane_keep;
  logic [OUT_WIDTH-1:0] acc_wr;

  assign s_ready = rst_n && (state_q == FILL);

  always_comb begin
    in_xfer    = s_valid && s_ready;
    slot_free  = !m_valid_q || m_ready;
    completing = (cnt_q == CNT_W'(RATIO - 1)) || s_last;
    keep_full  = keep_mask(32'(cnt_q), RATIO);
    lane_keep  = keep_full[RATIO-1:0];

    // Lanes above cnt are always zero because acc is cleared whenever a word leaves it.
    acc_wr = acc_q;
    for (int i = 0; i < RATIO; i++) begin
      if (cnt_q == CNT_W'(i)) acc_wr[i*IN_WIDTH +: IN_WIDTH] = s_data;
    end

    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    hold_keep_d = hold_keep_q;
    hold_last_d = hold_last_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_keep_d    = m_keep_q;
    m_last_d    = m_last_q;

    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    case (state_q)
      FILL: begin
        if (in_xfer) begin
          if (completing) begin
            cnt_d = '0;
            if (slot_free) begin
              m_valid_d = 1'b1;
              m_data_d  = acc_wr;
              m_keep_d  = lane_keep;
              m_last_d  = s_last;
              acc_d     = '0;
            end else begin
              acc_d       = acc_wr;
              hold_keep_d = lane_keep;
              hold_last_d = s_last;
              state_d     = HOLD;
            end
          end else begin
            acc_d = acc_wr;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (slot_free) begin
          m_valid_d = 1'b1;
          m_data_d  = acc_q;
          m_keep_d  = hold_keep_q;
          m_last_d  = hold_last_q;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      acc_q       <= '0;
      hold_keep_q <= '0;
      hold_last_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_keep_q    <= '0;
      m_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      hold_keep_q <= hold_keep_d;
      hold_last_q <= hold_last_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_keep_q    <= m_keep_d;
      m_last_q    <= m_last_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign m_last  = m_last_q;

  a_params_legal: assert property (@(posedge clk)
    (IN_WIDTH >= 1) && (RATIO >= 2) && (RATIO <= KEEP_MAX));

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_keep) && $stable(m_last)));

  a_hold_no_ready: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == HOLD) |-> !s_ready);

endmodule
`default_nettype wire

// File: tb/tb_wid_beat_packer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_wid_beat_packer : directed + streaming bench with word scoreboard   |
// | Rev 1.0 : initial release                                              |
// +-----------------------------------------------------------------------+
module tb_wid_beat_packer;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;

  word_t       sb[$];
  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  int          stall_cnt = 0;
  bit          streaming = 1'b0;
  logic [31:0] mdata = '0;
  int          mcnt = 0;

  wid_beat_packer #(.IN_WIDTH(8), .RATIO(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_last (s_last),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_keep (m_keep),
    .m_last (m_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: lanes fill little-endian, word closes at 4 lanes or on last.
  task automatic model_accept(input logic [7:0] d, input bit l);
    word_t w;
    mdata[mcnt*8 +: 8] = d;
    if (mcnt == 3 || l) begin
      w.data = mdata;
      w.keep = 4'((32'd1 << (mcnt + 1)) - 1);
      w.last = l;
      sb.push_back(w);
      mdata = '0;
      mcnt  = 0;
    end else begin
      mcnt++;
    end
  endtask

  task automatic send(input logic [7:0] d, input bit l);
    bit ok;
    ok      = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send_accept_timeout", {63'd0, ok}, 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (ok) model_accept(d, l);
  endtask

  always @(negedge clk) begin
    if (streaming && !s_ready) stall_cnt++;
    if (rst_n && m_valid && m_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_word: observed=%h expected=none", m_data);
      end
      if (sb.size() != 0) begin
        word_t e;
        e = sb.pop_front();
        pops++;
        checks++;
        assert (m_data === e.data && m_keep === e.keep && m_last === e.last) else begin
          errors++;
          $error("FAIL word: observed data=%h keep=%b last=%b expected data=%h keep=%b last=%b",
                 m_data, m_keep, m_last, e.data, e.keep, e.last);
        end
      end
    end
  end

  initial begin
    int p0;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_m_data", {32'd0, m_data}, 64'd0);
    chk("rst_m_keep", {60'd0, m_keep}, 64'd0);
    chk("rst_m_last", {63'd0, m_last}, 64'd0);
    chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_ready", {63'd0, s_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Full word
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    chk("full_latency_valid", {63'd0, m_valid}, 64'd1);
    chk("full_data", {32'd0, m_data}, 64'h44332211);
    chk("full_keep", {60'd0, m_keep}, 64'hF);
    chk("full_last", {63'd0, m_last}, 64'd0);

    // Partial flush
    send(8'hAA, 0); send(8'hBB, 1);
    chk("partial_data", {32'd0, m_data}, 64'h0000BBAA);
    chk("partial_keep", {60'd0, m_keep}, 64'h3);
    chk("partial_last", {63'd0, m_last}, 64'd1);

    // Single-beat packet
    send(8'h5C, 1);
    chk("single_data", {32'd0, m_data}, 64'h0000005C);
    chk("single_keep", {60'd0, m_keep}, 64'h1);
    chk("single_last", {63'd0, m_last}, 64'd1);
    @(posedge clk);
    #1;

    // Backpressure
    m_ready = 1'b0;
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    for (int i = 0; i < 4; i++) begin
      send(8'(8'h55 + 8'h11 * i), 0);
      chk("bp_hold_valid", {63'd0, m_valid}, 64'd1);
      chk("bp_hold_data", {32'd0, m_data}, 64'h44332211);
    end
    chk("bp_s_ready_low", {63'd0, s_ready}, 64'd0);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_second_valid", {63'd0, m_valid}, 64'd1);
    chk("bp_second_data", {32'd0, m_data}, 64'h88776655);
    chk("bp_s_ready_back", {63'd0, s_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Reset mid-word
    send(8'h01, 0); send(8'h02, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mdata = '0;
    mcnt  = 0;
    chk("midrst_m_valid", {63'd0, m_valid}, 64'd0);
    p0 = pops;
    send(8'h10, 0); send(8'h20, 0); send(8'h30, 0); send(8'h40, 0);
    chk("midrst_data", {32'd0, m_data}, 64'h40302010);
    chk("midrst_keep", {60'd0, m_keep}, 64'hF);
    @(posedge clk);
    #1;
    chk("midrst_one_word", 64'(pops - p0), 64'd1);

    // Streaming
    p0        = pops;
    stall_cnt = 0;
    streaming = 1'b1;
    for (int i = 0; i < 64; i++) send(8'($urandom_range(0, 255)), 0);
    repeat (3) @(posedge clk);
    #1;
    streaming = 1'b0;
    chk("stream_words", 64'(pops - p0), 64'd16);
    chk("stream_no_stall", 64'(stall_cnt), 64'd0);

    for (int t = 0; t < 50 && sb.size() != 0; t++) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
